// File: rtl/noc_pkg.sv
// Shared NoC packet definitions: PE-side 33-bit packet layout and builders.
package noc_pkg;
  localparam int PKT_W = 33;
  localparam int ADDR_W = 4;
  localparam logic [ADDR_W-1:0] MEM_WRAPPER_ADDR = 4'd13;

  typedef enum logic {PKT_FILTER = 1'b0, PKT_IFMAP = 1'b1} pkt_type_e;

  typedef struct packed {
    pkt_type_e         typ;
    logic [ADDR_W-1:0] dst;
    logic [ADDR_W-1:0] src;
    logic [23:0]       payload;
  } noc_pkt_t;

  function automatic noc_pkt_t mk_filter_pkt(input logic [ADDR_W-1:0] dst,
                                             input logic [ADDR_W-1:0] src,
                                             input logic [23:0] row);
    noc_pkt_t p;
    p.typ     = PKT_FILTER;
    p.dst     = dst;
    p.src     = src;
    p.payload = row;
    return p;
  endfunction

  // Window arrives already zero-extended to the payload width.
  function automatic noc_pkt_t mk_ifmap_pkt(input logic [ADDR_W-1:0] dst,
                                            input logic [ADDR_W-1:0] src,
                                            input logic [23:0] win);
    noc_pkt_t p;
    p.typ     = PKT_IFMAP;
    p.dst     = dst;
    p.src     = src;
    p.payload = win;
    return p;
  endfunction
endpackage

// File: rtl/pe_packet_dispatcher.sv
// Memory-wrapper source node: reads filter rows then ifmap windows and emits PE packets.
// Optional DISPATCH_STATS_EN adds saturating pkt_count / stall_count outputs.
module pe_packet_dispatcher
  import noc_pkg::*;
#(
  parameter int NUM_PE = 3,
  parameter int NUM_TS = 10,
  parameter int FILTER_W = 8,
  parameter int IFMAP_W = 9,
  parameter logic [ADDR_W-1:0] SRC_ADDR = MEM_WRAPPER_ADDR,
  parameter int IF_ADDR_W = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic                  filter_rd_en,
  output logic [3:0]            filter_rd_addr,
  input  logic [3*FILTER_W-1:0] filter_rd_data,
  output logic                  ifmap_rd_en,
  output logic [IF_ADDR_W-1:0]  ifmap_rd_addr,
  input  logic [IFMAP_W-1:0]    ifmap_rd_data,
  output logic                  pkt_valid,
  input  logic                  pkt_ready,
  output logic [PKT_W-1:0]      pkt_data
`ifdef DISPATCH_STATS_EN
  ,
  output logic [15:0]           pkt_count,
  output logic [15:0]           stall_count
`endif
);

  localparam int TS_W = (NUM_TS > 1) ? $clog2(NUM_TS) : 1;
  localparam logic [3:0] LAST_PE = 4'(NUM_PE - 1);
  localparam logic [TS_W-1:0] LAST_TS = TS_W'(NUM_TS - 1);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_RD   = 3'd1;
  localparam logic [2:0] S_CAP  = 3'd2;
  localparam logic [2:0] S_SEND = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;

  localparam logic PH_FILT = 1'b0;
  localparam logic PH_IFM  = 1'b1;

  if (NUM_PE < 1 || NUM_PE > 12) begin : g_chk_pe
    $error("NUM_PE must be in 1..12");
  end
  if (NUM_TS * NUM_PE > (1 << IF_ADDR_W)) begin : g_chk_addr
    $error("ifmap address ts*NUM_PE+pe does not fit IF_ADDR_W");
  end
  if (3 * FILTER_W != 24 || IFMAP_W > 24) begin : g_chk_payload
    $error("filter row must be 24 bits and ifmap window at most 24 bits");
  end

  logic [2:0]      state;
  logic            phase;
  logic [3:0]      pe_cnt;
  logic [TS_W-1:0] ts_cnt;

  // Strobes decode straight from the RD state so data lands while in CAP.
  assign filter_rd_en   = (state == S_RD) && (phase == PH_FILT);
  assign ifmap_rd_en    = (state == S_RD) && (phase == PH_IFM);
  assign filter_rd_addr = pe_cnt;
  assign ifmap_rd_addr  = IF_ADDR_W'(32'(ts_cnt) * 32'(NUM_PE) + 32'(pe_cnt));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      phase     <= PH_FILT;
      pe_cnt    <= '0;
      ts_cnt    <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pkt_valid <= 1'b0;
      pkt_data  <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: if (start) begin
          phase  <= PH_FILT;
          pe_cnt <= '0;
          ts_cnt <= '0;
          busy   <= 1'b1;
          state  <= S_RD;
        end
        S_RD: state <= S_CAP;
        S_CAP: begin
          pkt_data  <= (phase == PH_FILT) ? mk_filter_pkt(pe_cnt, SRC_ADDR, filter_rd_data)
                                          : mk_ifmap_pkt(pe_cnt, SRC_ADDR, 24'(ifmap_rd_data));
          pkt_valid <= 1'b1;
          state     <= S_SEND;
        end
        S_SEND: if (pkt_ready) begin
          pkt_valid <= 1'b0;
          if (pe_cnt != LAST_PE) begin
            pe_cnt <= pe_cnt + 4'd1;
            state  <= S_RD;
          end else begin
            pe_cnt <= '0;
            if (phase == PH_FILT) begin
              phase <= PH_IFM;
              state <= S_RD;
            end else if (ts_cnt != LAST_TS) begin
              ts_cnt <= ts_cnt + 1'b1;
              state  <= S_RD;
            end else begin
              done  <= 1'b1;
              busy  <= 1'b0;
              state <= S_DONE;
            end
          end
        end
        S_DONE: state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef DISPATCH_STATS_EN
  always_ff @(posedge clk) begin
    if (!rst_n || (state == S_IDLE && start)) begin
      pkt_count   <= '0;
      stall_count <= '0;
    end else begin
      if (pkt_valid && pkt_ready && pkt_count != 16'hFFFF)
        pkt_count <= pkt_count + 16'd1;
      if (pkt_valid && !pkt_ready && stall_count != 16'hFFFF)
        stall_count <= stall_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pe_packet_dispatcher.sv
// Randomized self-checking bench for pe_packet_dispatcher against a packet-list model.
module tb_pe_packet_dispatcher;
  localparam int NP = 3;
  localparam int NT = 2;
  localparam int NPKT = NP * (1 + NT);
  localparam int BUDGET = 2000;

  logic        clk, rst_n, start, pkt_ready;
  logic        busy, done, filter_rd_en, ifmap_rd_en, pkt_valid;
  logic [3:0]  filter_rd_addr;
  logic [23:0] filter_rd_data;
  logic [7:0]  ifmap_rd_addr;
  logic [8:0]  ifmap_rd_data;
  logic [32:0] pkt_data;
`ifdef DISPATCH_STATS_EN
  logic [15:0] pkt_count, stall_count;
`endif

  pe_packet_dispatcher #(.NUM_PE(NP), .NUM_TS(NT)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
    .filter_rd_en(filter_rd_en), .filter_rd_addr(filter_rd_addr), .filter_rd_data(filter_rd_data),
    .ifmap_rd_en(ifmap_rd_en), .ifmap_rd_addr(ifmap_rd_addr), .ifmap_rd_data(ifmap_rd_data),
    .pkt_valid(pkt_valid), .pkt_ready(pkt_ready), .pkt_data(pkt_data)
`ifdef DISPATCH_STATS_EN
    , .pkt_count(pkt_count), .stall_count(stall_count)
`endif
  );

  int checks = 0, failures = 0;
  int cyc = 0, start_cyc = 0, done_cnt = 0, both_rd = 0, unstable = 0;
  int rmode = 0;  // 0: ready high, 1: random, 2: driven by the test
  logic [23:0] filt_mem [0:15];
  logic [8:0]  ifm_mem [0:255];
  logic [32:0] rx_q[$], exp_q[$];
  int          rise_q[$];
  logic        prev_valid = 0, prev_ready = 0;
  logic [32:0] prev_data = '0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  always @(posedge clk) begin
    if (filter_rd_en) filter_rd_data <= filt_mem[filter_rd_addr];
    if (ifmap_rd_en)  ifmap_rd_data  <= ifm_mem[ifmap_rd_addr];
  end

  always @(posedge clk) begin
    #1;
    if (rmode == 0) pkt_ready = 1'b1;
    else if (rmode == 1) pkt_ready = 1'($urandom_range(0, 1));
  end

  always @(negedge clk) begin
    if (pkt_valid && pkt_ready) rx_q.push_back(pkt_data);
    if (done) done_cnt++;
    if (pkt_valid && !prev_valid) rise_q.push_back(cyc);
    if (filter_rd_en && ifmap_rd_en) both_rd++;
    if (pkt_valid && prev_valid && !prev_ready && pkt_data !== prev_data) unstable++;
    prev_valid = pkt_valid;
    prev_ready = pkt_ready;
    prev_data  = pkt_data;
  end

  // Expected stream: every filter row in PE order, then each timestep's windows in PE order.
  function automatic void build_model();
    exp_q.delete();
    for (int p = 0; p < NP; p++) exp_q.push_back({1'b0, 4'(p), 4'd13, filt_mem[p]});
    for (int t = 0; t < NT; t++)
      for (int p = 0; p < NP; p++)
        exp_q.push_back({1'b1, 4'(p), 4'd13, 15'd0, ifm_mem[t * NP + p]});
  endfunction

  task automatic fill_mem();
    for (int i = 0; i < 16; i++) filt_mem[i] = 24'($urandom);
    for (int i = 0; i < 256; i++) ifm_mem[i] = 9'($urandom);
  endtask

  task automatic pulse_start();
    @(posedge clk); #1 start = 1'b1; start_cyc = cyc;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic wait_done(output bit ok);
    int n = 0;
    while (done_cnt == 0 && n < BUDGET) begin @(negedge clk); n++; end
    ok = (done_cnt != 0);
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({busy, done, pkt_valid, filter_rd_en, ifmap_rd_en} !== 5'b0 || pkt_data !== 33'd0) begin
      failures++;
      $display("FAIL reset: busy=%b done=%b valid=%b rd=%b%b data=%h, required all zero",
               busy, done, pkt_valid, filter_rd_en, ifmap_rd_en, pkt_data);
    end
    @(negedge clk) rst_n = 1'b1;
  endtask

  task automatic test_filter_ifmap();
    bit ok; int bad = 0;
    fill_mem();
    filt_mem[0] = 24'h030201; filt_mem[1] = 24'h060504; filt_mem[2] = 24'h090807;
    ifm_mem[4] = 9'h1A5;
    build_model();
    rmode = 0; rx_q.delete(); done_cnt = 0; both_rd = 0;
    pulse_start();
    wait_done(ok);
    checks++;
    if (!ok || rx_q.size() != NPKT) begin
      failures++; $display("FAIL basic_count: got %0d packets done=%0d, required %0d", rx_q.size(), ok, NPKT);
    end
    if (rx_q.size() == NPKT) begin
      checks++;
      if (rx_q[0] !== 33'h0_0D030201 || rx_q[1] !== 33'h0_1D060504 || rx_q[2] !== 33'h0_2D090807) begin
        failures++; $display("FAIL filter_pkts: got %h %h %h, required 00D030201 01D060504 02D090807", rx_q[0], rx_q[1], rx_q[2]);
      end
      checks++;
      if (rx_q[NP + 1 * NP + 1] !== 33'h1_1D0001A5) begin
        failures++; $display("FAIL ifmap_ts1_pe1: got %h, required 11D0001A5", rx_q[NP + NP + 1]);
      end
      for (int i = 0; i < NPKT; i++) if (rx_q[i] !== exp_q[i]) bad++;
      checks++;
      if (bad != 0) begin failures++; $display("FAIL basic_stream: %0d packets differ from model, required 0", bad); end
    end
    checks++;
    if (done_cnt != 1 || busy !== 1'b0 || both_rd != 0) begin
      failures++; $display("FAIL basic_end: done_cnt=%0d busy=%b both_rd=%0d, required 1 0 0", done_cnt, busy, both_rd);
    end
`ifdef DISPATCH_STATS_EN
    checks++;
    if (pkt_count !== 16'(NPKT) || stall_count !== 16'd0) begin
      failures++; $display("FAIL basic_stats: pkt=%0d stall=%0d, required %0d 0", pkt_count, stall_count, NPKT);
    end
`endif
  endtask

  task automatic test_random();
    for (int it = 0; it < 4; it++) begin
      bit ok; int bad = 0;
      fill_mem(); build_model();
      rmode = 1; rx_q.delete(); done_cnt = 0;
      pulse_start();
      wait_done(ok);
      rmode = 0;
      if (rx_q.size() == NPKT) for (int i = 0; i < NPKT; i++) if (rx_q[i] !== exp_q[i]) bad++;
      checks++;
      if (!ok || rx_q.size() != NPKT || bad != 0 || done_cnt != 1 || unstable != 0) begin
        failures++;
        $display("FAIL random_%0d: pkts=%0d bad=%0d done_cnt=%0d unstable=%0d, required %0d 0 1 0",
                 it, rx_q.size(), bad, done_cnt, unstable, NPKT);
      end
    end
  endtask

  task automatic test_backpressure();
    bit ok; int n = 0; int bad = 0; int moved = 0; int rds = 0;
    logic [32:0] snap;
    fill_mem(); build_model();
    rmode = 2; pkt_ready = 1'b1; rx_q.delete(); done_cnt = 0;
    pulse_start();
    while (rx_q.size() < 1 && n < BUDGET) begin @(negedge clk); n++; end
    @(posedge clk); #1 pkt_ready = 1'b0;
    n = 0;
    while (!pkt_valid && n < BUDGET) begin @(negedge clk); n++; end
    snap = pkt_data;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (pkt_data !== snap || !pkt_valid) moved++;
      if (filter_rd_en || ifmap_rd_en) rds++;
    end
    pkt_ready = 1'b1;
    rmode = 0;
    wait_done(ok);
    checks++;
    if (moved != 0 || rds != 0 || snap !== exp_q[1]) begin
      failures++; $display("FAIL bp_hold: data_changes=%0d rd_en_cycles=%0d held=%h, required 0 0 %h", moved, rds, snap, exp_q[1]);
    end
    if (rx_q.size() == NPKT) for (int i = 0; i < NPKT; i++) if (rx_q[i] !== exp_q[i]) bad++;
    checks++;
    if (!ok || rx_q.size() != NPKT || bad != 0) begin
      failures++; $display("FAIL bp_stream: pkts=%0d bad=%0d, required %0d 0", rx_q.size(), bad, NPKT);
    end
`ifdef DISPATCH_STATS_EN
    checks++;
    if (stall_count !== 16'd5 || pkt_count !== 16'(NPKT)) begin
      failures++; $display("FAIL bp_stats: stall=%0d pkt=%0d, required 5 %0d", stall_count, pkt_count, NPKT);
    end
`endif
  endtask

  task automatic test_start_busy();
    int n = 0; int bad = 0; int woke = 0;
    fill_mem(); build_model();
    rmode = 1; rx_q.delete(); done_cnt = 0;
    pulse_start();
    while (rx_q.size() < 2 && n < BUDGET) begin @(negedge clk); n++; end
    pulse_start();
    n = 0;
    while (!done && n < BUDGET) begin @(negedge clk); n++; end
    start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    rmode = 0;
    for (int i = 0; i < 8; i++) begin @(negedge clk); if (busy || pkt_valid) woke++; end
    if (rx_q.size() == NPKT) for (int i = 0; i < NPKT; i++) if (rx_q[i] !== exp_q[i]) bad++;
    checks++;
    if (rx_q.size() != NPKT || bad != 0 || done_cnt != 1) begin
      failures++; $display("FAIL start_busy: pkts=%0d bad=%0d done_cnt=%0d, required %0d 0 1", rx_q.size(), bad, done_cnt, NPKT);
    end
    checks++;
    if (woke != 0) begin failures++; $display("FAIL start_at_done: active_cycles=%0d, required 0", woke); end
  endtask

  task automatic test_mid_reset();
    bit ok; int n = 0; int bad = 0;
    fill_mem();
    filt_mem[0] = 24'h030201; filt_mem[1] = 24'h060504; filt_mem[2] = 24'h090807;
    build_model();
    rmode = 0; rx_q.delete(); done_cnt = 0;
    pulse_start();
    while (rx_q.size() < 3 && n < BUDGET) begin @(negedge clk); n++; end
    @(posedge clk); #1 rmode = 2; pkt_ready = 1'b0;
    n = 0;
    while (!pkt_valid && n < BUDGET) begin @(negedge clk); n++; end
    rst_n = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (pkt_valid !== 1'b0 || busy !== 1'b0 || pkt_data !== 33'd0) begin
      failures++; $display("FAIL mid_reset: valid=%b busy=%b data=%h, required 0 0 0", pkt_valid, busy, pkt_data);
    end
    @(negedge clk) rst_n = 1'b1;
    repeat (6) @(negedge clk);
    checks++;
    if (done_cnt != 0) begin failures++; $display("FAIL mid_reset_done: done_cnt=%0d, required 0", done_cnt); end
    rmode = 0; rx_q.delete();
    pulse_start();
    wait_done(ok);
    if (rx_q.size() == NPKT) for (int i = 0; i < NPKT; i++) if (rx_q[i] !== exp_q[i]) bad++;
    checks++;
    if (!ok || rx_q.size() != NPKT || rx_q[0] !== 33'h0_0D030201 || bad != 0) begin
      failures++; $display("FAIL restart: pkts=%0d first=%h bad=%0d, required %0d 00D030201 0",
                           rx_q.size(), (rx_q.size() > 0) ? rx_q[0] : 33'd0, bad, NPKT);
    end
  endtask

  task automatic test_spacing();
    bit ok; int bad = 0;
    fill_mem();
    rmode = 0; rise_q.delete(); done_cnt = 0;
    pulse_start();
    wait_done(ok);
    checks++;
    if (!ok || rise_q.size() != NPKT || rise_q[0] - start_cyc != 3) begin
      failures++; $display("FAIL first_latency: rises=%0d latency=%0d, required %0d 3",
                           rise_q.size(), (rise_q.size() > 0) ? rise_q[0] - start_cyc : -1, NPKT);
    end
    for (int i = 1; i < rise_q.size(); i++) if (rise_q[i] - rise_q[i-1] != 3) bad++;
    checks++;
    if (bad != 0) begin failures++; $display("FAIL spacing: %0d intervals not 3 cycles, required 0", bad); end
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; pkt_ready = 1'b1;
    filter_rd_data = '0; ifmap_rd_data = '0;
    test_reset();
    test_filter_ifmap();
    test_random();
    test_backpressure();
    test_start_busy();
    test_mid_reset();
    test_spacing();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
